// File: rtl/icache_assoc_pkg.sv
// Shared types and default geometry for the set-associative instruction cache.
// Imported by the refill FSM and the cache top.
package icache_assoc_pkg;

   localparam int ICACHE_WAYS       = 2;
   localparam int ICACHE_SETS       = 16;
   localparam int ICACHE_LINE_WORDS = 4;
   localparam int ADDR_WIDTH        = 32;
   localparam int INST_WIDTH        = 32;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_REFILL = 2'd1,
      ST_FILL   = 2'd2
   } refill_state_e;

   // Index width that stays at least one bit wide for degenerate sizes.
   function automatic int min1_clog2(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/icache_refill_fsm.sv
// Line refill engine: walks one cache line word-by-word from memctrl into a
// line buffer, then raises a one-cycle fill strobe unless a flush aborted it.
module icache_refill_fsm
   import icache_assoc_pkg::*;
#(
   parameter int LINE_WORDS = ICACHE_LINE_WORDS,
   parameter int ADDR_W     = ADDR_WIDTH,
   parameter int INST_W     = INST_WIDTH
) (
   input  logic                             clk,
   input  logic                             rst_n,
   input  logic                             i_rdy,
   input  logic                             i_start,
   input  logic [ADDR_W-1:0]                i_base,
   input  logic                             i_flush,
   input  logic                             i_mem_valid,
   input  logic [INST_W-1:0]                i_mem_data,
   output refill_state_e                    o_state,
   output logic                             o_mem_req,
   output logic [ADDR_W-1:0]                o_mem_addr,
   output logic [LINE_WORDS-1:0][INST_W-1:0] o_line,
   output logic                             o_fill_we,
   output logic                             o_busy
);

   localparam int CNT_W = min1_clog2(LINE_WORDS);
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(LINE_WORDS - 1);

   refill_state_e                     r_state;
   refill_state_e                     w_next;
   logic [CNT_W-1:0]                  r_cnt;
   logic                              r_abort;
   logic [ADDR_W-1:0]                 r_base;
   logic [LINE_WORDS-1:0][INST_W-1:0] r_line;
   logic                              w_last_word;

   assign w_last_word = i_mem_valid && (r_cnt == LAST_CNT);

   always_comb begin
      w_next     = r_state;
      o_mem_req  = 1'b0;
      o_mem_addr = '0;
      o_fill_we  = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (i_start) w_next = ST_REFILL;
         end
         ST_REFILL: begin
            o_mem_req  = 1'b1;
            o_mem_addr = r_base + (ADDR_W'(r_cnt) << 2);
            if (w_last_word) w_next = ST_FILL;
         end
         ST_FILL: begin
            o_fill_we = !r_abort;
            w_next    = ST_IDLE;
         end
         default: w_next = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= ST_IDLE;
         r_cnt   <= '0;
         r_abort <= 1'b0;
         r_base  <= '0;
      end else if (i_rdy) begin
         r_state <= w_next;
         case (r_state)
            ST_IDLE: begin
               if (i_start) begin
                  r_base  <= i_base;
                  r_cnt   <= '0;
                  r_abort <= 1'b0;
               end
            end
            ST_REFILL: begin
               // A flush mid-refill still drains the line so memctrl is never orphaned.
               if (i_flush) r_abort <= 1'b1;
               if (i_mem_valid) r_cnt <= w_last_word ? '0 : r_cnt + CNT_W'(1);
            end
            ST_FILL: r_abort <= 1'b0;
            default: r_abort <= 1'b0;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (i_rdy && (r_state == ST_REFILL) && i_mem_valid) r_line[r_cnt] <= i_mem_data;
   end

   assign o_state = r_state;
   assign o_line  = r_line;
   assign o_busy  = (r_state != ST_IDLE);

endmodule

// File: rtl/icache_assoc.sv
// Set-associative instruction cache: same-cycle hit path, per-set round-robin
// replacement, fence.i flush, and a line refill engine toward memctrl.
module icache_assoc
   import icache_assoc_pkg::*;
#(
   parameter int WAYS       = ICACHE_WAYS,
   parameter int SETS       = ICACHE_SETS,
   parameter int LINE_WORDS = ICACHE_LINE_WORDS,
   parameter int ADDR_W     = ADDR_WIDTH,
   parameter int INST_W     = INST_WIDTH
) (
   input  logic              clk,
   input  logic              rst_n_in,
   input  logic              rdy_in,
   input  logic              inst_en,
   input  logic [ADDR_W-1:0] next_PC,
   input  logic              flush,
   output logic              cache_rdy,
   output logic [INST_W-1:0] next_inst_out,
   output logic              mem_req,
   output logic [ADDR_W-1:0] mem_addr,
   input  logic              mem_valid,
   input  logic [INST_W-1:0] mem_data,
   output logic              busy
);

   localparam int OFF_W  = $clog2(LINE_WORDS);
   localparam int OFFS_W = min1_clog2(LINE_WORDS);
   localparam int IDX_W  = $clog2(SETS);
   localparam int TAG_W  = ADDR_W - 2 - OFF_W - IDX_W;
   localparam int WAY_W  = min1_clog2(WAYS);
   localparam logic [ADDR_W-1:0] OFF_MASK = ADDR_W'(LINE_WORDS * 4 - 1);

   typedef logic [LINE_WORDS-1:0][INST_W-1:0] line_t;

   logic [SETS-1:0][WAYS-1:0]  r_valid;
   logic [TAG_W-1:0]           r_tag  [SETS][WAYS];
   line_t                      r_data [SETS][WAYS];
   logic [SETS-1:0][WAY_W-1:0] r_rr;

   logic [IDX_W-1:0]  r_fill_idx;
   logic [TAG_W-1:0]  r_fill_tag;
   logic [WAY_W-1:0]  r_victim;

   logic [OFFS_W-1:0] w_off;
   logic [IDX_W-1:0]  w_idx;
   logic [TAG_W-1:0]  w_tag;
   logic [ADDR_W-1:0] w_base;
   logic              w_hit;
   logic [WAY_W-1:0]  w_hit_way;
   logic [WAY_W-1:0]  w_victim;
   logic              w_idle;
   logic              w_start;
   logic              w_fill_we;
   logic              w_install;
   refill_state_e     w_state;
   line_t             w_line;

   assign w_off  = next_PC[2 +: OFFS_W] & OFFS_W'(LINE_WORDS - 1);
   assign w_idx  = next_PC[OFF_W + 2 +: IDX_W];
   assign w_tag  = next_PC[ADDR_W-1 -: TAG_W];
   assign w_base = next_PC & ~OFF_MASK;

   // Descending scan so the lowest matching / lowest invalid way wins.
   always_comb begin
      w_hit     = 1'b0;
      w_hit_way = '0;
      w_victim  = r_rr[w_idx];
      for (int w = WAYS - 1; w >= 0; w--) begin
         if (r_valid[w_idx][w] && (r_tag[w_idx][w] == w_tag)) begin
            w_hit     = 1'b1;
            w_hit_way = WAY_W'(w);
         end
         if (!r_valid[w_idx][w]) w_victim = WAY_W'(w);
      end
   end

   assign w_idle        = (w_state == ST_IDLE);
   assign cache_rdy     = inst_en && w_idle && w_hit;
   assign next_inst_out = cache_rdy ? r_data[w_idx][w_hit_way][w_off] : '0;
   assign w_start       = inst_en && w_idle && !w_hit && !flush;
   assign w_install     = w_fill_we && !flush;

   icache_refill_fsm #(
      .LINE_WORDS (LINE_WORDS),
      .ADDR_W     (ADDR_W),
      .INST_W     (INST_W)
   ) u_refill (
      .clk         (clk),
      .rst_n       (rst_n_in),
      .i_rdy       (rdy_in),
      .i_start     (w_start),
      .i_base      (w_base),
      .i_flush     (flush),
      .i_mem_valid (mem_valid),
      .i_mem_data  (mem_data),
      .o_state     (w_state),
      .o_mem_req   (mem_req),
      .o_mem_addr  (mem_addr),
      .o_line      (w_line),
      .o_fill_we   (w_fill_we),
      .o_busy      (busy)
   );

   always_ff @(posedge clk or negedge rst_n_in) begin
      if (!rst_n_in) begin
         r_valid    <= '0;
         r_rr       <= '0;
         r_fill_idx <= '0;
         r_fill_tag <= '0;
         r_victim   <= '0;
      end else if (rdy_in) begin
         if (w_start) begin
            r_fill_idx <= w_idx;
            r_fill_tag <= w_tag;
            r_victim   <= w_victim;
         end
         if (flush) begin
            r_valid <= '0;
         end else if (w_install) begin
            r_valid[r_fill_idx][r_victim] <= 1'b1;
         end
         if (w_install) r_rr[r_fill_idx] <= (WAYS == 1) ? '0 : r_victim + WAY_W'(1);
      end
   end

   // Tag and data stay unreset so they can map onto RAM.
   always_ff @(posedge clk) begin
      if (rdy_in && w_install) begin
         r_tag[r_fill_idx][r_victim]  <= r_fill_tag;
         r_data[r_fill_idx][r_victim] <= w_line;
      end
   end

endmodule
